// File: rtl/fetch_buffer.sv
// Instruction fetch queue between the I-cache response and the if_to_id register.
// Accepts 0-4 instructions per cycle and presents the oldest 4 show-ahead to decode.
package fetch_buffer_pkg;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
  } DECODE_REQUIRE;
endpackage

module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flash,
  input  logic                       stall,
  input  logic                       in_valid,
  input  logic [31:0]                in_pc,
  input  logic [127:0]               in_inst,
  input  logic [2:0]                 in_cnt,
  output logic                       in_ready,
  output DECODE_REQUIRE [3:0]        if_out,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   inst_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          push;
  logic [2:0]    push_n;
  logic [2:0]    pop_n;

  // Ready depends only on registered count so fetch sees no input-to-output path.
  assign in_ready  = (count_q <= CW'(DEPTH - 4));
  assign occupancy = count_q;

  assign push   = in_valid & in_ready & ~flash;
  assign push_n = push ? in_cnt : 3'd0;

  always_comb begin
    pop_n = 3'd0;
    if (!stall) begin
      pop_n = (count_q >= CW'(4)) ? 3'd4 : count_q[2:0];
    end
  end

  always_comb begin
    head_d  = head_q + PW'(pop_n);
    tail_d  = tail_q + PW'(push_n);
    count_d = count_q + CW'(push_n) - CW'(pop_n);
    if (flash) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Pointer sums are PW bits wide, so a group straddling DEPTH-1 wraps to 0 in order.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (3'(k) < in_cnt) begin
          pc_q[tail_q + PW'(k)]   <= in_pc + (k * 4);
          inst_q[tail_q + PW'(k)] <= in_inst[32*k +: 32];
        end
      end
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      if_out[k] = '0;
      if (CW'(k) < count_q) begin
        if_out[k].valid = 1'b1;
        if_out[k].pc    = pc_q[head_q + PW'(k)];
        if_out[k].inst  = inst_q[head_q + PW'(k)];
      end
    end
  end

endmodule
